// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between IFU (read) and LSU (read/write).
// Latency: read 3 cycles accept-to-response, write ack 2; one transaction at a time, response held until resp ready.
module sram_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MASK_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_resp_valid,
   input  logic              ifu_resp_ready,
   output logic [DATA_W-1:0] ifu_rdata,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic              lsu_we,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [MASK_W-1:0] lsu_wmask,
   output logic              lsu_resp_valid,
   input  logic              lsu_resp_ready,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              mem_r_en,
   output logic              mem_w_en,
   output logic [ADDR_W-1:0] mem_raddr,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [MASK_W-1:0] mem_wmask,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
   typedef enum logic {OWN_IFU = 1'b0, OWN_LSU = 1'b1} owner_t;

   typedef struct packed {
      owner_t            owner;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [MASK_W-1:0] wmask;
   } req_t;

   state_t            state, state_nxt;
   owner_t            last_grant;
   req_t              req;
   logic [DATA_W-1:0] resp_data;
   logic              grant_ifu, grant_lsu;

   // On a tie the requester that did not win last time is granted.
   assign grant_ifu = ifu_req_valid & (~lsu_req_valid | (last_grant == OWN_LSU));
   assign grant_lsu = lsu_req_valid & (~ifu_req_valid | (last_grant == OWN_IFU));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      ifu_req_ready  = 1'b0;
      lsu_req_ready  = 1'b0;
      ifu_resp_valid = 1'b0;
      lsu_resp_valid = 1'b0;
      ifu_rdata      = '0;
      lsu_rdata      = '0;
      mem_r_en       = 1'b0;
      mem_w_en       = 1'b0;
      mem_raddr      = '0;
      mem_waddr      = '0;
      mem_wdata      = '0;
      mem_wmask      = '0;
      case (state)
         IDLE: begin
            ifu_req_ready = grant_ifu;
            lsu_req_ready = grant_lsu;
            if (grant_ifu | grant_lsu) state_nxt = ISSUE;
         end
         ISSUE: begin
            if (req.we) begin
               mem_w_en  = 1'b1;
               mem_waddr = req.addr;
               mem_wdata = req.wdata;
               mem_wmask = req.wmask;
               state_nxt = RESP;
            end else begin
               mem_r_en  = 1'b1;
               mem_raddr = req.addr;
               state_nxt = CAPTURE;
            end
         end
         CAPTURE: state_nxt = RESP;
         RESP: begin
            if (req.owner == OWN_IFU) begin
               ifu_resp_valid = 1'b1;
               ifu_rdata      = resp_data;
               if (ifu_resp_ready) state_nxt = IDLE;
            end else begin
               lsu_resp_valid = 1'b1;
               lsu_rdata      = resp_data;
               if (lsu_resp_ready) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch, round-robin history and response register.
   always_ff @(posedge clk) begin
      if (rst) begin
         req        <= '0;
         last_grant <= OWN_LSU;
         resp_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_ifu) begin
                  req.owner  <= OWN_IFU;
                  req.we     <= 1'b0;
                  req.addr   <= ifu_addr;
                  req.wdata  <= '0;
                  req.wmask  <= '0;
                  last_grant <= OWN_IFU;
               end else if (grant_lsu) begin
                  req.owner  <= OWN_LSU;
                  req.we     <= lsu_we;
                  req.addr   <= lsu_addr;
                  req.wdata  <= lsu_wdata;
                  req.wmask  <= lsu_wmask;
                  last_grant <= OWN_LSU;
               end
            end
            ISSUE:   if (req.we) resp_data <= '0;
            // SRAM output is only valid the cycle after the strobe.
            CAPTURE: resp_data <= mem_rdata;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: SRAM model plus per-scenario tasks and response scoreboards.
module tb_sram_arbiter;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int MASK_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              ifu_req_valid = 1'b0, ifu_req_ready;
   logic [ADDR_W-1:0] ifu_addr = '0;
   logic              ifu_resp_valid, ifu_resp_ready = 1'b0;
   logic [DATA_W-1:0] ifu_rdata;
   logic              lsu_req_valid = 1'b0, lsu_req_ready;
   logic              lsu_we = 1'b0;
   logic [ADDR_W-1:0] lsu_addr = '0;
   logic [DATA_W-1:0] lsu_wdata = '0;
   logic [MASK_W-1:0] lsu_wmask = '0;
   logic              lsu_resp_valid, lsu_resp_ready = 1'b0;
   logic [DATA_W-1:0] lsu_rdata;
   logic              mem_r_en, mem_w_en;
   logic [ADDR_W-1:0] mem_raddr, mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [MASK_W-1:0] mem_wmask;
   logic [DATA_W-1:0] mem_rdata;

   int checks = 0;
   int failures = 0;
   logic [DATA_W-1:0] ifu_q[$];
   logic [DATA_W-1:0] lsu_q[$];
   logic [DATA_W-1:0] exp_d;
   logic [DATA_W-1:0] sram [0:255];

   localparam logic [31:0] A_CODE = 32'h8000_0000;
   localparam logic [31:0] A_DATA = 32'h8000_0100;
   localparam logic [31:0] A_PULSE = 32'h8000_0200;

   sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
      .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Single-port SRAM: read data appears the cycle after the strobe, 0 otherwise.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) sram[i] <= 32'h0;
         sram[A_CODE[9:2]] <= 32'h0000_0413;
         mem_rdata <= 32'h0;
      end else begin
         if (mem_w_en)
            for (int b = 0; b < 4; b++)
               if (mem_wmask[b]) sram[mem_waddr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
         mem_rdata <= mem_r_en ? sram[mem_raddr[9:2]] : 32'h0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      checks++;
      if ({ifu_resp_valid, lsu_resp_valid, mem_r_en, mem_w_en} !== 4'b0) begin
         failures++; $display("FAIL reset_ctrl got=%b exp=0000", {ifu_resp_valid, lsu_resp_valid, mem_r_en, mem_w_en});
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({ifu_rdata, lsu_rdata, mem_raddr, mem_waddr, mem_wdata, mem_wmask} !== '0) begin
         failures++; $display("FAIL reset_data got nonzero ifu_rdata=%h lsu_rdata=%h raddr=%h waddr=%h", ifu_rdata, lsu_rdata, mem_raddr, mem_waddr);
      end
      checks++;
      if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin
         failures++; $display("FAIL reset_ready got=%b exp=00", {ifu_req_ready, lsu_req_ready});
      end
   endtask

   task automatic test_ifu_read();
      ifu_req_valid = 1'b1; ifu_addr = A_CODE; ifu_resp_ready = 1'b0;
      #1;
      checks++;
      if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
         failures++; $display("FAIL rd_req_ready got=%b exp=10", {ifu_req_ready, lsu_req_ready});
      end
      ifu_q.push_back(32'h0000_0413);
      tick();
      ifu_req_valid = 1'b0; ifu_addr = '0;
      checks++;
      if ({mem_r_en, mem_w_en, mem_raddr} !== {2'b10, A_CODE}) begin
         failures++; $display("FAIL rd_issue got r=%b w=%b raddr=%h exp r=1 w=0 raddr=%h", mem_r_en, mem_w_en, mem_raddr, A_CODE);
      end
      tick();
      checks++;
      if ({mem_r_en, mem_raddr, ifu_resp_valid} !== '0) begin
         failures++; $display("FAIL rd_capture got r=%b raddr=%h vld=%b exp 0", mem_r_en, mem_raddr, ifu_resp_valid);
      end
      tick();
      checks++;
      if ({ifu_resp_valid, lsu_resp_valid, lsu_rdata} !== {2'b10, 32'h0}) begin
         failures++; $display("FAIL rd_resp_vld got ifu=%b lsu=%b lsu_rdata=%h exp 1 0 0", ifu_resp_valid, lsu_resp_valid, lsu_rdata);
      end
      ifu_resp_ready = 1'b1;
      exp_d = ifu_q.pop_front();
      checks++;
      if (ifu_rdata !== exp_d) begin
         failures++; $display("FAIL rd_data got=%h exp=%h", ifu_rdata, exp_d);
      end
      tick();
      ifu_resp_ready = 1'b0;
      checks++;
      if (ifu_resp_valid !== 1'b0) begin
         failures++; $display("FAIL rd_resp_drop got=%b exp=0", ifu_resp_valid);
      end
   endtask

   task automatic test_lsu_write_read();
      lsu_resp_ready = 1'b1;
      lsu_req_valid = 1'b1; lsu_we = 1'b1; lsu_addr = A_DATA; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F;
      #1;
      checks++;
      if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
         failures++; $display("FAIL wr_req_ready got=%b exp=01", {ifu_req_ready, lsu_req_ready});
      end
      lsu_q.push_back(32'h0);
      tick();
      lsu_req_valid = 1'b0;
      checks++;
      if ({mem_w_en, mem_r_en, mem_waddr, mem_wdata, mem_wmask} !== {2'b10, A_DATA, 32'hDEAD_BEEF, 8'h0F}) begin
         failures++; $display("FAIL wr_issue got w=%b r=%b waddr=%h wdata=%h wmask=%h", mem_w_en, mem_r_en, mem_waddr, mem_wdata, mem_wmask);
      end
      tick();
      exp_d = lsu_q.pop_front();
      checks++;
      if ({lsu_resp_valid, lsu_rdata, mem_w_en} !== {1'b1, exp_d, 1'b0}) begin
         failures++; $display("FAIL wr_ack got vld=%b rdata=%h w=%b exp vld=1 rdata=%h w=0", lsu_resp_valid, lsu_rdata, mem_w_en, exp_d);
      end
      tick();
      lsu_req_valid = 1'b1; lsu_we = 1'b0;
      lsu_q.push_back(32'hDEAD_BEEF);
      tick();
      lsu_req_valid = 1'b0;
      tick(); tick();
      exp_d = lsu_q.pop_front();
      checks++;
      if ({lsu_resp_valid, lsu_rdata} !== {1'b1, exp_d}) begin
         failures++; $display("FAIL wr_readback got vld=%b rdata=%h exp vld=1 rdata=%h", lsu_resp_valid, lsu_rdata, exp_d);
      end
      tick();
   endtask

   task automatic test_round_robin();
      int grants = 0;
      int both = 0;
      ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
      ifu_req_valid = 1'b1; ifu_addr = A_CODE;
      lsu_req_valid = 1'b1; lsu_we = 1'b0; lsu_addr = A_DATA;
      for (int cyc = 0; cyc < 60; cyc++) begin
         #1;
         if (ifu_req_ready && lsu_req_ready) both++;
         if (ifu_req_ready || lsu_req_ready) begin
            checks++;
            if (ifu_req_ready !== (grants % 2 == 0)) begin
               failures++; $display("FAIL rr_order grant%0d got ifu=%b exp ifu=%b", grants, ifu_req_ready, (grants % 2 == 0));
            end
            if (ifu_req_ready) ifu_q.push_back(32'h0000_0413);
            else               lsu_q.push_back(32'hDEAD_BEEF);
            grants++;
         end
         if (ifu_resp_valid && ifu_q.size() > 0) begin
            exp_d = ifu_q.pop_front();
            checks++;
            if (ifu_rdata !== exp_d) begin
               failures++; $display("FAIL rr_ifu_data got=%h exp=%h", ifu_rdata, exp_d);
            end
         end
         if (lsu_resp_valid && lsu_q.size() > 0) begin
            exp_d = lsu_q.pop_front();
            checks++;
            if (lsu_rdata !== exp_d) begin
               failures++; $display("FAIL rr_lsu_data got=%h exp=%h", lsu_rdata, exp_d);
            end
         end
         tick();
         if (grants >= 6) begin ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; end
         if (grants >= 6 && ifu_q.size() == 0 && lsu_q.size() == 0) break;
      end
      checks++;
      if (grants != 6 || ifu_q.size() != 0 || lsu_q.size() != 0) begin
         failures++; $display("FAIL rr_count got grants=%0d pending=%0d exp grants=6 pending=0", grants, ifu_q.size() + lsu_q.size());
      end
      checks++;
      if (both != 0) begin
         failures++; $display("FAIL rr_both_ready got=%0d exp=0", both);
      end
      ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
      tick(); tick();
   endtask

   task automatic test_hold_resp();
      ifu_req_valid = 1'b1; ifu_addr = A_CODE;
      lsu_req_valid = 1'b1; lsu_we = 1'b0; lsu_addr = A_DATA;
      ifu_q.push_back(32'h0000_0413);
      tick();
      ifu_req_valid = 1'b0;
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({ifu_resp_valid, ifu_rdata, mem_r_en, mem_w_en, lsu_req_ready} !== {1'b1, 32'h0000_0413, 3'b000}) begin
            failures++; $display("FAIL hold_cyc%0d got vld=%b rdata=%h r=%b w=%b lsu_rdy=%b", i, ifu_resp_valid, ifu_rdata, mem_r_en, mem_w_en, lsu_req_ready);
         end
         tick();
      end
      ifu_resp_ready = 1'b1; lsu_req_valid = 1'b0;
      exp_d = ifu_q.pop_front();
      checks++;
      if (ifu_rdata !== exp_d) begin
         failures++; $display("FAIL hold_data got=%h exp=%h", ifu_rdata, exp_d);
      end
      tick();
      ifu_resp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      lsu_resp_ready = 1'b1;
      lsu_req_valid = 1'b1; lsu_we = 1'b0; lsu_addr = A_DATA;
      tick();
      lsu_req_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({lsu_resp_valid, mem_r_en, mem_w_en, mem_raddr, mem_waddr, mem_wdata, mem_wmask} !== '0) begin
            failures++; $display("FAIL midrst_cyc%0d got vld=%b r=%b w=%b raddr=%h", i, lsu_resp_valid, mem_r_en, mem_w_en, mem_raddr);
         end
         tick();
      end
      ifu_req_valid = 1'b1; ifu_addr = A_CODE; lsu_req_valid = 1'b1; ifu_resp_ready = 1'b1;
      #1;
      checks++;
      if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
         failures++; $display("FAIL midrst_tie got=%b exp=10", {ifu_req_ready, lsu_req_ready});
      end
      ifu_q.push_back(32'h0000_0413);
      tick();
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      tick(); tick();
      exp_d = ifu_q.pop_front();
      checks++;
      if ({ifu_resp_valid, ifu_rdata} !== {1'b1, exp_d}) begin
         failures++; $display("FAIL midrst_data got vld=%b rdata=%h exp vld=1 rdata=%h", ifu_resp_valid, ifu_rdata, exp_d);
      end
      tick();
      ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
   endtask

   task automatic test_valid_pulse();
      ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
      ifu_req_valid = 1'b1; ifu_addr = A_CODE;
      ifu_q.push_back(32'h0000_0413);
      tick();
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b1; lsu_we = 1'b1; lsu_addr = A_PULSE; lsu_wdata = 32'h1234_5678; lsu_wmask = 8'h0F;
      #1;
      checks++;
      if (lsu_req_ready !== 1'b0) begin
         failures++; $display("FAIL pulse_ready got=%b exp=0", lsu_req_ready);
      end
      tick();
      lsu_req_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (mem_w_en !== 1'b0 || lsu_resp_valid !== 1'b0 || (mem_r_en && mem_raddr == A_PULSE)) begin
            failures++; $display("FAIL pulse_cyc%0d got w=%b lsu_vld=%b raddr=%h exp no lsu access", i, mem_w_en, lsu_resp_valid, mem_raddr);
         end
         if (ifu_resp_valid && ifu_q.size() > 0) begin
            exp_d = ifu_q.pop_front();
            checks++;
            if (ifu_rdata !== exp_d) begin
               failures++; $display("FAIL pulse_ifu_data got=%h exp=%h", ifu_rdata, exp_d);
            end
         end
         tick();
      end
      ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_ifu_read();
      test_lsu_write_read();
      test_round_robin();
      test_hold_resp();
      test_reset_mid();
      test_valid_pulse();
      checks++;
      if (ifu_q.size() != 0 || lsu_q.size() != 0) begin
         failures++; $display("FAIL scoreboard_left got ifu=%0d lsu=%0d exp 0 0", ifu_q.size(), lsu_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
